// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC stream engine: FSM state encoding,
// the legal BITS_PER_CLK set and a generic bit-reversal function.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

  // Bit k set means BITS_PER_CLK == k is supported (1, 2, 4, 8).
  localparam logic [8:0] BPC_OK = 9'b1_0001_0110;

  // Reverse the low 'width' bits of value; bits above width come back zero.
  function automatic logic [31:0] reflect(input logic [31:0] value, input int width);
    logic [31:0] r;
    logic [4:0]  idx;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        idx  = 5'(width - 1 - i);
        r[i] = value[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational Galois-form CRC update folding N data bits into the register.
// data_in[N-1] is folded first; the caller presents bits in processing order.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h07,
  parameter int               N     = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [N-1:0]     data_in,
  output logic [CRC_W-1:0] crc_next
);

  logic [CRC_W-1:0] acc;

  // Unrolled bit-serial division: one shift/conditional-XOR per data bit.
  always_comb begin
    acc = crc_in;
    for (int i = N - 1; i >= 0; i--) begin
      if (acc[CRC_W-1] ^ data_in[i]) begin
        acc = {acc[CRC_W-2:0], 1'b0} ^ POLY;
      end else begin
        acc = {acc[CRC_W-2:0], 1'b0};
      end
    end
    crc_next = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Byte-stream CRC generator/checker. Accepts one byte per handshake, folds it
// BITS_PER_CLK bits per cycle and reports the final CRC plus a residue match
// flag for one cycle at the end of each frame.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W         = 8,
  parameter logic [CRC_W-1:0] POLY          = 'h07,
  parameter logic [CRC_W-1:0] INIT          = '0,
  parameter logic [CRC_W-1:0] XOR_OUT       = '0,
  parameter bit               REFLECT_IN    = 1'b0,
  parameter bit               REFLECT_OUT   = 1'b0,
  parameter int               BITS_PER_CLK  = 1,
  parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid,
  output logic             crc_ok
);

  localparam int       BPC_IDX   = (BITS_PER_CLK >= 1 && BITS_PER_CLK <= 8) ? BITS_PER_CLK : 0;
  localparam bit       BPC_LEGAL = BPC_OK[BPC_IDX];
  localparam int       STEPS     = 8 / (BPC_LEGAL ? BITS_PER_CLK : 1);
  localparam logic [2:0] LAST_CNT = 3'(STEPS - 1);

  if (!BPC_LEGAL) begin : g_bpc_illegal
    $error("crc_stream_engine: BITS_PER_CLK must be 1, 2, 4 or 8");
  end
  if (CRC_W < 8 || CRC_W > 32) begin : g_width_illegal
    $error("crc_stream_engine: CRC_W must be in 8..32");
  end

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [7:0]       sh_q;
  logic [2:0]       cnt_q;
  logic             last_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             crc_valid_q;
  logic             crc_ok_q;

  logic [7:0]        byte_in_d;
  logic [CRC_W-1:0]  crc_step_d;
  logic [CRC_W-1:0]  refl_d;
  logic [CRC_W-1:0]  fin_d;
  logic [BITS_PER_CLK-1:0] step_bits;

  // The shift register always presents its MSBs first, so LSB-first input
  // order is achieved by reversing the byte once at the handshake.
  always_comb begin
    byte_in_d = in_data;
    if (REFLECT_IN) begin
      byte_in_d = 8'(reflect(32'(in_data), 8));
    end
  end

  assign step_bits = sh_q[7 -: BITS_PER_CLK];

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .N     (BITS_PER_CLK)
  ) u_step (
    .crc_in   (crc_q),
    .data_in  (step_bits),
    .crc_next (crc_step_d)
  );

  // Final value computed from the last fold so it can be registered on entry to DONE.
  always_comb begin
    refl_d = CRC_W'(reflect(32'(crc_step_d), CRC_W));
    fin_d  = (REFLECT_OUT ? refl_d : crc_step_d) ^ XOR_OUT;
  end

  assign in_ready  = (state_q == IDLE) && !clr;
  assign busy      = (state_q != IDLE);
  assign crc_out   = crc_out_q;
  assign crc_valid = crc_valid_q;
  assign crc_ok    = crc_ok_q;

  // Frame FSM: accept byte, fold it over STEPS cycles, pulse the result on the last byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      sh_q        <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q    <= byte_in_d;
            last_q  <= in_last;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          crc_q <= crc_step_d;
          sh_q  <= sh_q << BITS_PER_CLK;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LAST_CNT) begin
            if (last_q) begin
              state_q     <= DONE;
              crc_out_q   <= fin_d;
              crc_ok_q    <= (fin_d == CHECK_RESIDUE);
              crc_valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          crc_q   <= INIT;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: six instances cover CRC-8 defaults,
// CRC-16/CCITT-FALSE at every legal BITS_PER_CLK and reflected CRC-32.
module tb_crc_stream_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] in_data;
  logic       in_last;
  logic [5:0] v_vec;
  logic [5:0] rdy_vec;
  logic [5:0] busy_vec;
  logic [5:0] cv_vec;
  logic [5:0] ok_vec;
  logic [7:0]  co8;
  logic [15:0] co16 [4];
  logic [31:0] co32;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          hs_cnt    [6];
  int          pulse_cnt [6];
  int          last_hs   [6];
  int          gap_min   [6];
  int          gap_max   [6];
  int          lat       [6];
  bit          have_hs   [6];
  logic [31:0] cap_val   [6];
  logic        cap_ok    [6];

  always #5 clk = ~clk;

  crc_stream_engine u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(v_vec[0]),
    .in_last(in_last), .in_ready(rdy_vec[0]), .busy(busy_vec[0]), .crc_out(co8),
    .crc_valid(cv_vec[0]), .crc_ok(ok_vec[0])
  );

  for (genvar g = 0; g < 4; g++) begin : g_c16
    crc_stream_engine #(
      .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .BITS_PER_CLK(1 << g)
    ) u_dut16 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(v_vec[g+1]),
      .in_last(in_last), .in_ready(rdy_vec[g+1]), .busy(busy_vec[g+1]), .crc_out(co16[g]),
      .crc_valid(cv_vec[g+1]), .crc_ok(ok_vec[g+1])
    );
  end

  crc_stream_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
    .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .BITS_PER_CLK(4)
  ) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(v_vec[5]),
    .in_last(in_last), .in_ready(rdy_vec[5]), .busy(busy_vec[5]), .crc_out(co32),
    .crc_valid(cv_vec[5]), .crc_ok(ok_vec[5])
  );

  function automatic logic [31:0] get_out(input int k);
    case (k)
      0:       return {24'h0, co8};
      1:       return {16'h0, co16[0]};
      2:       return {16'h0, co16[1]};
      3:       return {16'h0, co16[2]};
      4:       return {16'h0, co16[3]};
      default: return co32;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and result pulses mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    for (int k = 0; k < 6; k++) begin
      if (v_vec[k] && rdy_vec[k]) begin
        if (have_hs[k]) begin
          if (cyc - last_hs[k] < gap_min[k]) gap_min[k] = cyc - last_hs[k];
          if (cyc - last_hs[k] > gap_max[k]) gap_max[k] = cyc - last_hs[k];
        end
        hs_cnt[k]++;
        last_hs[k] = cyc;
        have_hs[k] = 1'b1;
      end
      if (cv_vec[k]) begin
        pulse_cnt[k]++;
        cap_val[k] = get_out(k);
        cap_ok[k]  = ok_vec[k];
        lat[k]     = cyc - last_hs[k];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input int s, input logic [7:0] d, input logic l);
    int n;
    in_data  = d;
    in_last  = l;
    v_vec[s] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rdy_vec[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("hs_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    v_vec[s] = 1'b0;
  endtask

  // variant 0: "123456789"; 1: plus 0xF4; 2: plus 0xF4 with 0x35 corrupted to 0x36.
  task automatic send_msg(input int s, input int variant);
    logic [7:0] m [10];
    int n;
    m = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    if (variant == 2) m[4] = 8'h36;
    n = (variant == 0) ? 9 : 10;
    have_hs[s] = 1'b0;
    gap_min[s] = 1000;
    gap_max[s] = 0;
    for (int i = 0; i < n; i++) send_byte(s, m[i], (i == n - 1));
  endtask

  task automatic wait_pulse(input int s, input int target, input string tag);
    int n;
    n = 0;
    while (pulse_cnt[s] < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq(tag, 32'(pulse_cnt[s]), 32'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs0;
    for (int k = 0; k < 6; k++) begin
      hs_cnt[k] = 0; pulse_cnt[k] = 0; last_hs[k] = 0; lat[k] = 0;
      gap_min[k] = 1000; gap_max[k] = 0; have_hs[k] = 1'b0;
      cap_val[k] = '0; cap_ok[k] = 1'b0;
    end
    rst_n = 1'b0; clr = 1'b0; v_vec = '0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check_eq("rst_ready", 32'(rdy_vec[0]), 32'd1);
    check_eq("rst_busy", 32'(busy_vec[0]), 32'd0);
    check_eq("rst_valid", 32'(cv_vec[0]), 32'd0);
    check_eq("rst_crc_out", get_out(0), 32'h0);
    check_eq("rst_crc_ok", 32'(ok_vec[0]), 32'd0);
    @(posedge clk);
    #1;

    // T1: CRC-8 defaults
    send_msg(0, 0);
    wait_pulse(0, 1, "t1_pulses");
    check_eq("t1_crc", cap_val[0], 32'hF4);
    check_eq("t1_ok", 32'(cap_ok[0]), 32'd0);
    check_eq("t1_gap_min", 32'(gap_min[0]), 32'd9);
    check_eq("t1_gap_max", 32'(gap_max[0]), 32'd9);
    check_eq("t1_latency", 32'(lat[0]), 32'd9);
    check_eq("t1_hold", get_out(0), 32'hF4);

    // T2: corrupted frame then frame with appended CRC
    send_msg(0, 2);
    wait_pulse(0, 2, "t2_bad_pulses");
    check_eq("t2_bad_ok", 32'(cap_ok[0]), 32'd0);
    send_msg(0, 1);
    wait_pulse(0, 3, "t2_good_pulses");
    check_eq("t2_good_crc", cap_val[0], 32'h00);
    check_eq("t2_good_ok", 32'(cap_ok[0]), 32'd1);

    // T3: CRC-16/CCITT-FALSE at 1, 2, 4, 8 bits per clock
    for (int g = 0; g < 4; g++) begin
      send_msg(g + 1, 0);
      wait_pulse(g + 1, 1, $sformatf("t3_b%0d_pulses", 1 << g));
      check_eq($sformatf("t3_b%0d_crc", 1 << g), cap_val[g+1], 32'h29B1);
      check_eq($sformatf("t3_b%0d_gap_min", 1 << g), 32'(gap_min[g+1]), 32'((8 >> g) + 1));
      check_eq($sformatf("t3_b%0d_gap_max", 1 << g), 32'(gap_max[g+1]), 32'((8 >> g) + 1));
      check_eq($sformatf("t3_b%0d_latency", 1 << g), 32'(lat[g+1]), 32'((8 >> g) + 1));
    end

    // T4: reflected CRC-32
    send_msg(5, 0);
    wait_pulse(5, 1, "t4_pulses");
    check_eq("t4_crc", cap_val[5], 32'hCBF43926);

    // T5: clr in the middle of byte 5, then a byte offered while clr is high
    for (int i = 0; i < 5; i++) send_byte(0, 8'(8'h31 + i), 1'b0);
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    check_eq("t5_clr_ready_shift", 32'(rdy_vec[0]), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("t5_clr_busy", 32'(busy_vec[0]), 32'd0);
    check_eq("t5_clr_crc_hold", get_out(0), 32'h00);
    check_eq("t5_clr_ok_hold", 32'(ok_vec[0]), 32'd1);
    @(posedge clk);
    #1;
    hs0 = hs_cnt[0];
    clr = 1'b1; in_data = 8'h31; in_last = 1'b1; v_vec[0] = 1'b1;
    @(negedge clk);
    check_eq("t5_clr_ready_idle", 32'(rdy_vec[0]), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0; v_vec[0] = 1'b0;
    @(negedge clk);
    check_eq("t5_no_accept_hs", 32'(hs_cnt[0] - hs0), 32'd0);
    check_eq("t5_no_accept_busy", 32'(busy_vec[0]), 32'd0);
    @(posedge clk);
    #1;
    send_msg(0, 0);
    wait_pulse(0, 4, "t5_pulses");
    check_eq("t5_crc", cap_val[0], 32'hF4);

    // T6: reset mid-frame, then a back-to-back frame
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h31 + i), 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_ready", 32'(rdy_vec[0]), 32'd1);
    check_eq("t6_rst_busy", 32'(busy_vec[0]), 32'd0);
    check_eq("t6_rst_valid", 32'(cv_vec[0]), 32'd0);
    check_eq("t6_rst_crc_out", get_out(0), 32'h0);
    check_eq("t6_rst_crc_ok", 32'(ok_vec[0]), 32'd0);
    @(posedge clk);
    #1;
    hs0 = hs_cnt[0];
    send_msg(0, 0);
    wait_pulse(0, 5, "t6_pulses");
    check_eq("t6_crc", cap_val[0], 32'hF4);
    check_eq("t6_handshakes", 32'(hs_cnt[0] - hs0), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
